// File: rtl/sys_ctrl_pkg.sv
// sys_ctrl_pkg: opcodes, FSM state encoding and ALU operand addresses for sys_ctrl
package sys_ctrl_pkg;
  localparam logic [7:0] OPC_WR  = 8'hAA;
  localparam logic [7:0] OPC_RD  = 8'hBB;
  localparam logic [7:0] OPC_ALU = 8'hCC;
  localparam logic [7:0] OPC_NOP = 8'hDD;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_WR_ADDR  = 4'd1;
  localparam logic [3:0] S_WR_DATA  = 4'd2;
  localparam logic [3:0] S_RD_ADDR  = 4'd3;
  localparam logic [3:0] S_RD_WAIT  = 4'd4;
  localparam logic [3:0] S_OP_A     = 4'd5;
  localparam logic [3:0] S_OP_B     = 4'd6;
  localparam logic [3:0] S_ALU_FUN  = 4'd7;
  localparam logic [3:0] S_ALU_WAIT = 4'd8;
  localparam logic [3:0] S_TX_SEND  = 4'd9;
  localparam int OPA_ADDR = 0;
  localparam int OPB_ADDR = 1;
endpackage

// File: rtl/sys_ctrl.sv
// sys_ctrl: decodes UART byte frames into register-file/ALU commands and returns results to TX
module sys_ctrl
  import sys_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FUN_WIDTH  = 4,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  input  logic                  rx_err,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0] rf_wr_data,
  output logic                  rf_wr_en,
  output logic                  rf_rd_en,
  input  logic [DATA_WIDTH-1:0] rf_rd_data,
  input  logic                  rf_rd_valid,
  output logic [FUN_WIDTH-1:0]  alu_fun,
  output logic                  alu_en,
  output logic                  alu_gate_en,
  input  logic [OUT_WIDTH-1:0]  alu_out,
  input  logic                  alu_valid,
  output logic [OUT_WIDTH-1:0]  tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  cmd_drop
);
  logic [3:0]            state_q, state_d, next_op;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  rf_wr_en_q, rf_wr_en_d, rf_rd_en_q, rf_rd_en_d;
  logic [FUN_WIDTH-1:0]  alu_fun_q, alu_fun_d;
  logic                  alu_en_q, alu_en_d, gate_q, gate_d, fire_q, fire_d;
  logic [OUT_WIDTH-1:0]  tx_data_q, tx_data_d;
  logic                  tx_valid_q, tx_valid_d, cmd_drop_q, cmd_drop_d;
  logic                  byte_ok, busy;
  // fire_q delays alu_en one cycle behind the clock-gate enable so the ALU clock is running first
  always_comb begin
    byte_ok = rx_valid && !rx_err;
    busy = state_q == S_RD_WAIT || state_q == S_ALU_WAIT || state_q == S_TX_SEND;
    next_op = rx_data == DATA_WIDTH'(OPC_WR)  ? S_WR_ADDR :
              rx_data == DATA_WIDTH'(OPC_RD)  ? S_RD_ADDR :
              rx_data == DATA_WIDTH'(OPC_ALU) ? S_OP_A    :
              rx_data == DATA_WIDTH'(OPC_NOP) ? S_ALU_FUN : S_IDLE;
    state_d = state_q;
    rf_addr_d = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
    rf_wr_en_d = 1'b0;
    rf_rd_en_d = 1'b0;
    alu_fun_d = alu_fun_q;
    alu_en_d = fire_q;
    fire_d = 1'b0;
    gate_d = gate_q;
    tx_data_d = tx_data_q;
    tx_valid_d = tx_valid_q;
    cmd_drop_d = rx_valid && (rx_err || busy || (state_q == S_IDLE && next_op == S_IDLE));
    case (state_q)
      S_IDLE: state_d = byte_ok ? next_op : S_IDLE;
      S_WR_ADDR: if (byte_ok) begin
        rf_addr_d = rx_data[ADDR_WIDTH-1:0];
        state_d = S_WR_DATA;
      end
      S_WR_DATA: if (byte_ok) begin
        rf_wr_data_d = rx_data;
        rf_wr_en_d = 1'b1;
        state_d = S_IDLE;
      end
      S_RD_ADDR: if (byte_ok) begin
        rf_addr_d = rx_data[ADDR_WIDTH-1:0];
        rf_rd_en_d = 1'b1;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: if (rf_rd_valid) begin
        tx_data_d = OUT_WIDTH'(rf_rd_data);
        tx_valid_d = 1'b1;
        state_d = S_TX_SEND;
      end
      S_OP_A, S_OP_B: if (byte_ok) begin
        rf_addr_d = state_q == S_OP_A ? ADDR_WIDTH'(OPA_ADDR) : ADDR_WIDTH'(OPB_ADDR);
        rf_wr_data_d = rx_data;
        rf_wr_en_d = 1'b1;
        state_d = state_q == S_OP_A ? S_OP_B : S_ALU_FUN;
      end
      S_ALU_FUN: if (byte_ok) begin
        alu_fun_d = rx_data[FUN_WIDTH-1:0];
        gate_d = 1'b1;
        fire_d = 1'b1;
        state_d = S_ALU_WAIT;
      end
      S_ALU_WAIT: if (alu_valid && !fire_q) begin
        tx_data_d = alu_out;
        tx_valid_d = 1'b1;
        gate_d = 1'b0;
        state_d = S_TX_SEND;
      end
      S_TX_SEND: if (tx_ready) begin
        tx_valid_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rx_valid && rx_err && !busy) state_d = S_IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      rf_addr_q <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q <= 1'b0;
      rf_rd_en_q <= 1'b0;
      alu_fun_q <= '0;
      alu_en_q <= 1'b0;
      gate_q <= 1'b0;
      fire_q <= 1'b0;
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      cmd_drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rf_addr_q <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
      rf_wr_en_q <= rf_wr_en_d;
      rf_rd_en_q <= rf_rd_en_d;
      alu_fun_q <= alu_fun_d;
      alu_en_q <= alu_en_d;
      gate_q <= gate_d;
      fire_q <= fire_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      cmd_drop_q <= cmd_drop_d;
    end
  end
  assign rf_addr = rf_addr_q;
  assign rf_wr_data = rf_wr_data_q;
  assign rf_wr_en = rf_wr_en_q;
  assign rf_rd_en = rf_rd_en_q;
  assign alu_fun = alu_fun_q;
  assign alu_en = alu_en_q;
  assign alu_gate_en = gate_q;
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign cmd_drop = cmd_drop_q;
endmodule

// File: tb/tb_sys_ctrl.sv
// tb_sys_ctrl: directed self-checking bench for sys_ctrl
module tb_sys_ctrl;
  logic        CLK = 1'b0, RST = 1'b1;
  logic [7:0]  rx_data = '0, rf_rd_data = '0;
  logic        rx_valid = 1'b0, rx_err = 1'b0, rf_rd_valid = 1'b0, alu_valid = 1'b0, tx_ready = 1'b0;
  logic [15:0] alu_out = '0;
  logic [3:0]  rf_addr, alu_fun;
  logic [7:0]  rf_wr_data;
  logic [15:0] tx_data;
  logic        rf_wr_en, rf_rd_en, alu_en, alu_gate_en, tx_valid, cmd_drop;
  int checks = 0, errors = 0;
  sys_ctrl dut (
    .CLK(CLK), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .rf_addr(rf_addr), .rf_wr_data(rf_wr_data), .rf_wr_en(rf_wr_en), .rf_rd_en(rf_rd_en),
    .rf_rd_data(rf_rd_data), .rf_rd_valid(rf_rd_valid), .alu_fun(alu_fun), .alu_en(alu_en),
    .alu_gate_en(alu_gate_en), .alu_out(alu_out), .alu_valid(alu_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .cmd_drop(cmd_drop)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [7:0] b, input logic err);
    rx_data = b;
    rx_valid = 1'b1;
    rx_err = err;
    tick();
    rx_valid = 1'b0;
    rx_err = 1'b0;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    tick();
    tick();
    chk("rst_wr_en", {15'd0, rf_wr_en}, 16'd0);
    chk("rst_rd_en", {15'd0, rf_rd_en}, 16'd0);
    chk("rst_alu", {alu_fun, 2'b0, alu_en, alu_gate_en, 8'd0}, 16'd0);
    chk("rst_tx", {15'd0, tx_valid}, 16'd0);
    chk("rst_txd", tx_data, 16'h0000);
    chk("rst_rf", {4'd0, rf_addr, rf_wr_data}, 16'd0);
    chk("rst_drop", {15'd0, cmd_drop}, 16'd0);
    RST = 1'b0;
    tick();
    send(8'hAA, 1'b0);
    chk("wr_op_noen", {15'd0, rf_wr_en}, 16'd0);
    send(8'h05, 1'b0);
    chk("wr_addr_noen", {15'd0, rf_wr_en}, 16'd0);
    send(8'h3C, 1'b0);
    chk("wr_en", {15'd0, rf_wr_en}, 16'd1);
    chk("wr_addr", {12'd0, rf_addr}, 16'd5);
    chk("wr_data", {8'd0, rf_wr_data}, 16'h003C);
    chk("wr_notx", {15'd0, tx_valid}, 16'd0);
    tick();
    chk("wr_en_1cyc", {15'd0, rf_wr_en}, 16'd0);
    send(8'hBB, 1'b0);
    send(8'h05, 1'b0);
    chk("rd_en", {15'd0, rf_rd_en}, 16'd1);
    chk("rd_addr", {12'd0, rf_addr}, 16'd5);
    tick();
    chk("rd_en_1cyc", {15'd0, rf_rd_en}, 16'd0);
    chk("rd_wait_notx", {15'd0, tx_valid}, 16'd0);
    rf_rd_data = 8'h3C;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    chk("rd_txv", {15'd0, tx_valid}, 16'd1);
    chk("rd_txd", tx_data, 16'h003C);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rd_hold_v", {15'd0, tx_valid}, 16'd1);
      chk("rd_hold_d", tx_data, 16'h003C);
    end
    tx_ready = 1'b1;
    tick();
    chk("rd_txv_drop", {15'd0, tx_valid}, 16'd0);
    send(8'hCC, 1'b0);
    chk("alu_op_noen", {15'd0, rf_wr_en}, 16'd0);
    send(8'h0A, 1'b0);
    chk("alu_a_en", {15'd0, rf_wr_en}, 16'd1);
    chk("alu_a", {4'd0, rf_addr, rf_wr_data}, 16'h000A);
    send(8'h03, 1'b0);
    chk("alu_b_en", {15'd0, rf_wr_en}, 16'd1);
    chk("alu_b", {4'd0, rf_addr, rf_wr_data}, 16'h0103);
    chk("alu_gate_pre", {15'd0, alu_gate_en}, 16'd0);
    send(8'h00, 1'b0);
    chk("alu_fun_gate", {15'd0, alu_gate_en}, 16'd1);
    chk("alu_fun_noen", {14'd0, rf_wr_en, alu_en}, 16'd0);
    tick();
    chk("alu_en", {11'd0, alu_fun, alu_en}, 16'h0001);
    tick();
    chk("alu_en_1cyc", {14'd0, alu_en, alu_gate_en}, 16'h0001);
    alu_out = 16'h000D;
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("alu_txv", {14'd0, tx_valid, alu_gate_en}, 16'h0002);
    chk("alu_txd", tx_data, 16'h000D);
    tick();
    chk("alu_txv_drop", {15'd0, tx_valid}, 16'd0);
    send(8'hDD, 1'b0);
    send(8'h02, 1'b0);
    chk("nop_gate", {11'd0, alu_fun, alu_gate_en}, 16'h0005);
    chk("nop_nowr", {15'd0, rf_wr_en}, 16'd0);
    tick();
    chk("nop_en", {15'd0, alu_en}, 16'd1);
    tick();
    send(8'h11, 1'b0);
    chk("busy_drop", {15'd0, cmd_drop}, 16'd1);
    alu_out = 16'h1234;
    alu_valid = 1'b1;
    tick();
    alu_valid = 1'b0;
    chk("busy_drop_1cyc", {15'd0, cmd_drop}, 16'd0);
    chk("nop_txv", {15'd0, tx_valid}, 16'd1);
    chk("nop_txd", tx_data, 16'h1234);
    tick();
    chk("nop_txv_drop", {15'd0, tx_valid}, 16'd0);
    send(8'h55, 1'b0);
    chk("unk_drop", {15'd0, cmd_drop}, 16'd1);
    tick();
    chk("unk_drop_1cyc", {15'd0, cmd_drop}, 16'd0);
    send(8'hAA, 1'b0);
    chk("wr2_nodrop", {15'd0, cmd_drop}, 16'd0);
    send(8'h05, 1'b0);
    send(8'h3C, 1'b1);
    chk("err_drop", {15'd0, cmd_drop}, 16'd1);
    chk("err_nowr", {15'd0, rf_wr_en}, 16'd0);
    tick();
    chk("err_nowr_late", {15'd0, rf_wr_en}, 16'd0);
    send(8'hBB, 1'b0);
    send(8'h02, 1'b0);
    chk("err_idle_rd", {11'd0, rf_addr, rf_rd_en}, 16'h0005);
    rf_rd_data = 8'h99;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    chk("err_idle_txd", tx_data, 16'h0099);
    tick();
    chk("err_idle_txv", {15'd0, tx_valid}, 16'd0);
    send(8'hCC, 1'b0);
    send(8'h11, 1'b0);
    chk("opb_pre", {8'd0, rf_wr_data}, 16'h0011);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("rst2_rf", {4'd0, rf_addr, rf_wr_data}, 16'd0);
    chk("rst2_strobes", {12'd0, rf_wr_en, rf_rd_en, alu_en, alu_gate_en}, 16'd0);
    chk("rst2_tx", {14'd0, tx_valid, cmd_drop}, 16'd0);
    chk("rst2_txd", tx_data, 16'd0);
    send(8'hBB, 1'b0);
    send(8'h01, 1'b0);
    chk("rst2_rd", {11'd0, rf_addr, rf_rd_en}, 16'h0003);
    rf_rd_data = 8'h42;
    rf_rd_valid = 1'b1;
    tick();
    rf_rd_valid = 1'b0;
    chk("rst2_txv", {15'd0, tx_valid}, 16'd1);
    chk("rst2_txd2", tx_data, 16'h0042);
    tick();
    chk("rst2_txv_drop", {15'd0, tx_valid}, 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
